// File: rtl/fp_int2float_pkg.sv
// Shared constants, FSM state encoding and the IEEE-754 single payload layout
// for the sequential integer-to-float converter.
package fp_int2float_pkg;

    localparam int unsigned FP_EXP_BIAS    = 127;
    localparam int unsigned FP_FRAC_W      = 23;
    localparam int unsigned FP_EXP_W       = 8;
    localparam int unsigned INT_W_INTERNAL = 32;
    localparam int unsigned LZ_W           = 6;
    // Exponent of a value whose leading one sits in bit 31 of the magnitude
    localparam int unsigned EXP_TOP        = FP_EXP_BIAS + INT_W_INTERNAL - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        LZC   = 3'd2,
        SHIFT = 3'd3,
        PACK  = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_int2float_seq_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input reports 32.
module lzc32
    import fp_int2float_pkg::*;
(
    input  logic [INT_W_INTERNAL-1:0] i_data,
    output logic [LZ_W-1:0]           o_count
);

    // Ascending scan: the highest set bit is the last to write the count
    always_comb begin
        o_count = LZ_W'(INT_W_INTERNAL);
        for (int i = 0; i < 32; i++) begin
            if (i_data[i]) begin
                o_count = LZ_W'(31 - i);
            end
        end
    end

endmodule

// File: rtl/fp_int2float_seq.sv
// Multi-cycle signed integer to IEEE-754 single converter: accept, abs,
// leading-zero count, normalise, round-to-nearest-even pack, one-cycle done.
module fp_int2float_seq
    import fp_int2float_pkg::*;
#(
    parameter int unsigned INT_WIDTH = 32
)
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clk_en,
    input  logic [INT_WIDTH-1:0] dataa,
    output logic [31:0]          result,
    output logic                 done,
    output logic                 busy
);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_accept;
    logic                      w_done_nxt;
    logic                      w_busy_nxt;
    logic                      r_done;
    logic                      r_busy;

    logic signed [INT_WIDTH-1:0]  w_din;
    logic [INT_W_INTERNAL-1:0]    w_x_ext;
    logic [INT_W_INTERNAL-1:0]    r_x;
    logic [INT_W_INTERNAL-1:0]    w_mag;
    logic [INT_W_INTERNAL-1:0]    r_mag;
    logic                         r_sign;
    logic [LZ_W-1:0]              w_lz;
    logic [LZ_W-1:0]              r_lz;
    logic [INT_W_INTERNAL-1:0]    r_norm;
    logic [FP_EXP_W-1:0]          r_exp;

    logic [FP_FRAC_W-1:0]         w_frac;
    logic                         w_guard;
    logic                         w_sticky;
    logic                         w_round_up;
    logic [FP_FRAC_W:0]           w_frac_sum;
    fp32_t                        w_packed;
    fp32_t                        r_result;

    assign w_din   = dataa;
    assign w_x_ext = INT_W_INTERNAL'(w_din);
    // -2^31 negates to itself, which read as unsigned is the correct magnitude
    assign w_mag   = r_x[INT_W_INTERNAL-1] ? (~r_x + INT_W_INTERNAL'(1)) : r_x;

    lzc32 u_lzc32 (
        .i_data  (r_mag),
        .o_count (w_lz)
    );

    // Rounding and packing from the normalised magnitude
    always_comb begin
        w_frac     = r_norm[30:8];
        w_guard    = r_norm[7];
        w_sticky   = |r_norm[6:0];
        w_round_up = w_guard & (w_sticky | w_frac[0]);
        w_frac_sum = {1'b0, w_frac} + 24'(w_round_up);
        w_packed   = '0;
        // Normalised bit 31 clear only when the magnitude was zero: emit +0
        if (r_norm[31]) begin
            w_packed.sign = r_sign;
            w_packed.exp  = r_exp + FP_EXP_W'(w_frac_sum[FP_FRAC_W]);
            w_packed.frac = w_frac_sum[FP_FRAC_W-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (clk_en) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ABS;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ABS:     w_state_nxt = LZC;
            LZC:     w_state_nxt = SHIFT;
            SHIFT:   w_state_nxt = PACK;
            PACK:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
        w_done_nxt = (w_state_nxt == DONE);
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Datapath: each stage register loads only in its own state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x      <= '0;
            r_sign   <= 1'b0;
            r_mag    <= '0;
            r_lz     <= '0;
            r_norm   <= '0;
            r_exp    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_x <= w_x_ext;
            end
            unique case (r_state)
                ABS: begin
                    r_sign <= r_x[INT_W_INTERNAL-1];
                    r_mag  <= w_mag;
                end
                LZC: begin
                    r_lz <= w_lz;
                end
                SHIFT: begin
                    r_norm <= r_mag << r_lz;
                    r_exp  <= FP_EXP_W'(EXP_TOP - 32'(r_lz));
                end
                PACK: begin
                    r_result <= w_packed;
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = r_busy;

endmodule

// File: tb/tb_fp_int2float_seq.sv
// Directed bench for fp_int2float_seq: 32-bit and 16-bit builds side by side.
module tb_fp_int2float_seq;

    logic        clock;
    logic        reset_n;
    logic        clk_en;
    logic [31:0] dataa32;
    logic [15:0] dataa16;
    logic [31:0] result32;
    logic [31:0] result16;
    logic        done32;
    logic        done16;
    logic        busy32;
    logic        busy16;

    int n_vec = 0;
    int n_err = 0;

    fp_int2float_seq #(.INT_WIDTH(32)) dut32 (
        .clock   (clock),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .dataa   (dataa32),
        .result  (result32),
        .done    (done32),
        .busy    (busy32)
    );

    fp_int2float_seq #(.INT_WIDTH(16)) dut16 (
        .clock   (clock),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .dataa   (dataa16),
        .result  (result16),
        .done    (done16),
        .busy    (busy16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated conversion; latency counted in edges after the accepting edge
    task automatic run_conv(input logic [31:0] a, input logic [31:0] exp,
                            input bit sel16, input string tag);
        int n;
        @(negedge clock);
        clk_en  = 1'b1;
        dataa32 = a;
        dataa16 = a[15:0];
        @(negedge clock);
        clk_en = 1'b0;
        check(32'(sel16 ? busy16 : busy32), 32'd1, {tag, "_busy"});
        n = 0;
        while (((sel16 ? done16 : done32) !== 1'b1) && (n < 12)) begin
            @(negedge clock);
            n++;
        end
        check(32'(n), 32'd4, {tag, "_latency"});
        check(sel16 ? result16 : result32, exp, {tag, "_result"});
        @(negedge clock);
        check(sel16 ? {30'd0, done16, busy16} : {30'd0, done32, busy32}, 32'd0, {tag, "_idle"});
    endtask

    initial begin
        bit seen_done;
        reset_n = 1'b0;
        clk_en  = 1'b0;
        dataa32 = '0;
        dataa16 = '0;
        repeat (2) @(negedge clock);
        check(result32, 32'h0, "rst_result32");
        check({30'd0, done32, busy32}, 32'd0, "rst_done_busy32");
        check(result16, 32'h0, "rst_result16");
        reset_n = 1'b1;

        run_conv(32'd1,          32'h3F80_0000, 1'b0, "one");
        run_conv(32'hFFFF_FFFF,  32'hBF80_0000, 1'b0, "minus_one");
        run_conv(32'd0,          32'h0000_0000, 1'b0, "zero");
        run_conv(32'd1000,       32'h447A_0000, 1'b0, "k1000");
        run_conv(32'h8000_0000,  32'hCF00_0000, 1'b0, "int_min");
        run_conv(32'h7FFF_FFFF,  32'h4F00_0000, 1'b0, "int_max_carry");
        run_conv(32'd16777217,   32'h4B80_0000, 1'b0, "tie_down");
        run_conv(32'd16777219,   32'h4B80_0002, 1'b0, "tie_up");

        // clk_en held high: accepts every 5th cycle, mid-flight dataa changes ignored
        @(negedge clock);
        clk_en  = 1'b1;
        dataa32 = 32'd3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check(32'(done32), 32'((k == 4) || (k == 9)), $sformatf("b2b_done_c%0d", k));
            if (k == 4) check(result32, 32'h4040_0000, "b2b_result_3");
            if (k == 9) check(result32, 32'h40A0_0000, "b2b_result_5");
            if (k == 0) dataa32 = 32'd5;
            if (k == 5) dataa32 = 32'd9;
            if (k == 9) clk_en = 1'b0;
        end
        @(negedge clock);
        check(32'(busy32), 32'd0, "b2b_busy_after");

        // Reset asserted while in SHIFT aborts the conversion
        @(negedge clock);
        clk_en  = 1'b1;
        dataa32 = 32'd7;
        @(negedge clock);
        clk_en = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check(result32, 32'h0, "abort_result");
        check({30'd0, done32, busy32}, 32'd0, "abort_done_busy");
        @(negedge clock);
        reset_n = 1'b1;
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (done32 === 1'b1) seen_done = 1'b1;
        end
        check(32'(seen_done), 32'd0, "abort_no_done");
        run_conv(32'd1000, 32'h447A_0000, 1'b0, "after_abort");

        // 16-bit build
        run_conv(32'h0000_8000, 32'hC700_0000, 1'b1, "w16_min");
        run_conv(32'h0000_7FFF, 32'h46FF_FE00, 1'b1, "w16_max");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
